// File: rtl/line_option_sequencer.sv
// rtl/line_option_sequencer.sv - circular option FIFO replaying candidate lines to the nonogram solver
// Loads tagged index/option words, then cycles them past the solver until solved or no pass makes progress.
module line_option_sequencer #(
  parameter int SIZE  = 3,
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              num_rows,
  input  logic [3:0]              num_cols,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    load_is_index,
  input  logic [SIZE-1:0]         load_data,
  input  logic                    load_done,
  output logic [SIZE-1:0]         option,
  output logic                    valid_op,
  output logic                    started,
  input  logic                    put_back_to_FIFO,
  input  logic                    solved,
  output logic [2*SIZE*CNT_W-1:0] old_options_amnt,
  output logic                    busy,
  output logic                    done,
  output logic                    stalled,
  output logic                    load_err,
  output logic [7:0]              pass_count
);
  localparam int LINES = 2*SIZE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_STALL} state_t;
  state_t r_state, w_next;

  logic [SIZE:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [CNT_W-1:0]  r_amnt [LINES];
  logic [SIZE-1:0]   r_cur_line, r_run_line, r_option;
  logic              r_have_idx, r_tag, r_valid, r_started;
  logic              r_first_pass, r_changed, r_load_err;
  logic [7:0]        r_pass_count;
  logic [3:0]        r_num_rows, r_num_cols;

  logic              w_in_load, w_acc, w_idx_bad, w_opt_bad, w_load_push;
  logic              w_run_push, w_drop, w_can_pop, w_boundary, w_stall_bnd;
  logic              w_pop, w_push, w_empty;
  logic [SIZE:0]     w_head, w_wdata;
  logic [7:0]        w_dims_unused;

  // Board dimensions are latched for debug visibility only.
  assign w_dims_unused = {r_num_rows, r_num_cols};

  assign load_ready  = ((r_state == S_IDLE) || (r_state == S_LOAD)) && (r_count < CW'(DEPTH));
  assign w_in_load   = (r_state == S_LOAD) || ((r_state == S_IDLE) && load_valid);
  assign w_acc       = load_valid && load_ready;
  assign w_idx_bad   = load_is_index && ({1'b0, load_data} >= (SIZE+1)'(LINES));
  assign w_opt_bad   = !load_is_index && !r_have_idx;
  assign w_load_push = w_acc && !w_idx_bad && !w_opt_bad;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_run_push  = (r_state == S_RUN) && r_valid && (r_tag || put_back_to_FIFO);
  assign w_drop      = (r_state == S_RUN) && r_valid && !r_tag && !put_back_to_FIFO;
  assign w_can_pop   = (r_state == S_RUN) && !solved && (r_count != '0);
  assign w_boundary  = w_can_pop && w_head[SIZE] && (w_head[SIZE-1:0] == '0);
  // A drop by the option in flight this cycle still counts toward the pass that is ending.
  assign w_stall_bnd = w_boundary && !r_first_pass && !(r_changed || w_drop);
  assign w_pop       = w_can_pop && !w_stall_bnd;
  assign w_empty     = (r_state == S_RUN) && (r_count == '0) && !w_run_push;
  assign w_push      = w_load_push || w_run_push;
  assign w_wdata     = w_load_push ? {load_is_index, load_data} : {r_tag, r_option};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (load_valid) w_next = S_LOAD;
      S_RUN: begin
        if (solved)                      w_next = S_DONE;
        else if (w_stall_bnd || w_empty) w_next = S_STALL;
      end
      default: w_next = r_state;
    endcase
    if (w_in_load && load_done)
      w_next = ((r_count == '0) && !w_load_push) ? S_STALL : S_RUN;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_cur_line   <= '0;
      r_run_line   <= '0;
      r_option     <= '0;
      r_have_idx   <= 1'b0;
      r_tag        <= 1'b0;
      r_valid      <= 1'b0;
      r_started    <= 1'b0;
      r_first_pass <= 1'b1;
      r_changed    <= 1'b0;
      r_load_err   <= 1'b0;
      r_pass_count <= '0;
      r_num_rows   <= '0;
      r_num_cols   <= '0;
      for (int i = 0; i < LINES; i++) r_amnt[i] <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      r_valid   <= w_pop;
      r_started <= w_pop && w_boundary && r_first_pass;
      if (w_pop) begin
        r_option <= w_head[SIZE-1:0];
        r_tag    <= w_head[SIZE];
        if (w_head[SIZE]) r_run_line <= w_head[SIZE-1:0];
      end

      if (w_pop && w_boundary) begin
        r_first_pass <= 1'b0;
        r_changed    <= 1'b0;
        if (r_pass_count != 8'hFF) r_pass_count <= r_pass_count + 8'd1;
      end else if (w_drop) begin
        r_changed <= 1'b1;
      end

      if (w_acc && load_is_index && !w_idx_bad) begin
        r_cur_line <= load_data;
        r_have_idx <= 1'b1;
      end
      if (w_acc && (w_idx_bad || w_opt_bad)) r_load_err <= 1'b1;
      if (w_in_load && load_done) begin
        r_num_rows <= num_rows;
        r_num_cols <= num_cols;
      end

      for (int i = 0; i < LINES; i++) begin
        if (w_load_push && !load_is_index && (r_cur_line == SIZE'(i)) && (r_amnt[i] != '1))
          r_amnt[i] <= r_amnt[i] + CNT_W'(1);
        else if (w_drop && (r_run_line == SIZE'(i)) && (r_amnt[i] != '0))
          r_amnt[i] <= r_amnt[i] - CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < LINES; g++) begin : g_amnt
    assign old_options_amnt[g*CNT_W +: CNT_W] = r_amnt[g];
  end

  assign option     = r_option;
  assign valid_op   = r_valid;
  assign started    = r_started;
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign stalled    = (r_state == S_STALL);
  assign load_err   = r_load_err;
  assign pass_count = r_pass_count;
endmodule

// File: doc/line_option_sequencer.md
Name: line_option_sequencer

Overview:
- Upstream feeder for the nonogram `solver` stage.
- Holds every candidate line option in a circular FIFO and replays it to the solver one pass at a time: a line-index word, then that line's options.
- Re-queues options the solver keeps (`put_back_to_FIFO`), drops the rest, and maintains the per-line remaining-option counts the solver consumes as `old_options_amnt`.
- Stops when the solver reports `solved`, or when a full pass eliminates nothing (stall).

Parameters:
- SIZE, 3: max board dimension. Option word width is SIZE bits; 2*SIZE must be <= 2^SIZE.
- DEPTH, 64: FIFO entries, power of two.
- CNT_W, 7: width of each per-line option counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- num_rows  in  4  board rows; sampled at load_done
- num_cols  in  4  board cols; sampled at load_done
- load_valid  in  1  loader word valid
- load_ready  out  1  FIFO can accept a load word
- load_is_index  in  1  1 = line-index word, 0 = option word
- load_data  in  SIZE  index or option bitmask
- load_done  in  1  pulse: loading complete, begin solving
- option  out  SIZE  word to solver (index or option)
- valid_op  out  1  option valid this cycle
- started  out  1  high with the first index word of the first pass only
- put_back_to_FIFO  in  1  solver keeps the current option
- solved  in  1  solver reports board complete
- old_options_amnt  out  2*SIZE x CNT_W  remaining options per line (rows 0..SIZE-1, then cols)
- busy  out  1  state is RUN
- done  out  1  terminated because solved
- stalled  out  1  terminated because a pass made no progress
- load_err  out  1  sticky: bad index or option before any index
- pass_count  out  8  completed passes, saturating at 255

Behaviour:
- Reset (async, any state): state = IDLE; FIFO empty (rd_ptr = wr_ptr = count = 0); all counters 0; `valid_op`, `started`, `busy`, `done`, `stalled`, `load_err` = 0; `option` = 0; `pass_count` = 0. A reset mid-RUN discards all contents.
- States: IDLE -> LOAD -> RUN -> {DONE, STALL}. DONE and STALL hold until reset.
- IDLE: the first `load_valid` moves to LOAD. The word is accepted in that same cycle and treated as a LOAD word.
- LOAD:
  - `load_ready` = (count < DEPTH).
  - A word is accepted when `load_valid && load_ready`; it is written with a 1-bit tag (= `load_is_index`).
  - Index word: sets `cur_line` = `load_data`.
    - If `load_data` >= 2*SIZE, the word is dropped and `load_err` is set.
  - Option word: `old_options_amnt[cur_line]` += 1, saturating at 2^CNT_W-1.
    - An option word before any index word is dropped and sets `load_err`.
  - `load_done`: latch `num_rows`/`num_cols`, then go to RUN. If the FIFO is empty, go to STALL instead.
  - Load words arriving with `load_done` in the same cycle are accepted first.
- RUN:
  - One FIFO pop per cycle while count > 0.
  - `option`/`valid_op` are registered: an entry popped in cycle N is driven in cycle N+1 with `valid_op` = 1.
  - `put_back_to_FIFO` is sampled in the same cycle the option is driven (cycle N+1).
  - Index entries are re-pushed unconditionally; `put_back_to_FIFO` is ignored for them.
  - Option entry with `put_back_to_FIFO` = 1: re-pushed at `wr_ptr`.
  - Option entry with `put_back_to_FIFO` = 0: dropped. The count for its line decrements (floor 0) and pass flag `changed` is set.
  - A simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH. Count never grows in RUN.
  - A pass boundary is popping an index entry with value 0.
    - Not the first pass and `changed` = 0: go to STALL without driving that index.
    - Otherwise: clear `changed` and increment `pass_count`.
  - `started` = 1 only in the cycle the very first index-0 word is driven.
  - `solved` sampled high in any RUN cycle: go to DONE next cycle. `valid_op` drops. The in-flight option is still written back per `put_back_to_FIFO`.
  - FIFO empty in RUN: `valid_op` = 0; go to STALL.
- DONE/STALL: `valid_op` = 0. `old_options_amnt` and FIFO contents frozen for debug.
- `busy` = (state == RUN).

Test Plan:
- Load 3x3 (idx0, 110, 011; idx1, 100, 010, 001; idx2, 101; idx3, 101; idx4, 110, 011; idx5, 100, 010, 001), then `load_done` -> `old_options_amnt` = {2,3,1,1,2,3}. First driven word is 000 with `started` = 1, then 110, 011.
- Solver drops row1 option 100 (put_back = 0) -> `old_options_amnt[1]` 3 -> 2. Next pass row1 emits only 010, 001. FIFO count down by 1.
- Solver keeps everything for one full pass -> at the second idx-0 pop, `stalled` = 1, `valid_op` = 0, `pass_count` = 1.
- Assert `solved` mid-pass -> `done` = 1 next cycle, `valid_op` = 0, `busy` = 0.
- Fill with DEPTH words -> `load_ready` = 0 and the extra word is not written. Index 7 with SIZE = 3 -> `load_err` = 1 and the word is dropped.
- Reset asserted mid-RUN (asynchronous, between edges) -> all outputs 0 immediately and state IDLE. A reload works normally.
